// File: rtl/mask_poly_writer_if.sv
// Sample stream (sampler -> writer) and y-polynomial RAM write port (writer -> RAM).
// The slave modport is the writer's view; the master modport is the view of the
// sampler/RAM environment around it.
interface mask_poly_writer_if #(
  parameter int unsigned SAMPLER_W = 4,
  parameter int unsigned SAMPLE_W  = 23,
  parameter int unsigned ADDR_W    = 9
);
  logic [SAMPLER_W*SAMPLE_W-1:0] samples_i;
  logic                          valid_i;
  logic                          ready_o;
  logic                          mem_ready;
  logic                          mem_we;
  logic [ADDR_W-1:0]             mem_addr;
  logic [SAMPLER_W*SAMPLE_W-1:0] mem_wdata;

  modport slave (
    input  samples_i, valid_i, mem_ready,
    output ready_o, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output samples_i, valid_i, mem_ready,
    input  ready_o, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mask_poly_writer.sv
// Mask polynomial writer: turns raw ExpandMask samples r into y = gamma1 - r mod q and
// writes them, SAMPLER_W coefficients per word, into the y polynomial RAM.
// Two-stage pipeline; mem_ready low freezes everything.
// Optional macro MASK_WR_RANGE_CHK_EN enables the sticky r >= 2*gamma1 range check.
module mask_poly_writer #(
  parameter int unsigned SAMPLER_W = 4,
  parameter int unsigned SAMPLE_W  = 23,
  parameter int unsigned ADDR_W    = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          sec_lvl,
  mask_poly_writer_if.slave   bus,
  output logic                poly_done,
  output logic                set_done,
  output logic                busy,
  output logic                range_err
);

  localparam int unsigned BEATS = 256 / SAMPLER_W;
  localparam int unsigned DW    = SAMPLE_W + 1;
  localparam logic [DW-1:0] Q   = DW'(8380417);
  localparam logic [7:0] BEAT_LAST = 8'(BEATS - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [2:0]    num_poly_q, lvl_polys;
  logic          g19_q, lvl_g19;
  logic [7:0]    beat_q;
  logic [2:0]    poly_q;
  logic [DW-1:0] gamma1;
  logic          accept, last_beat, last_poly;

  logic [DW-1:0] d_comb [SAMPLER_W];
  logic [DW-1:0] corr_full [SAMPLER_W];
  logic [SAMPLER_W*SAMPLE_W-1:0] corr;

  logic          s1_valid_q, s1_pd_q, s1_sd_q;
  logic [DW-1:0] s1_d_q [SAMPLER_W];
  logic [ADDR_W-1:0] s1_addr_q;

  logic          s2_valid_q, s2_pd_q, s2_sd_q;
  logic [ADDR_W-1:0] s2_addr_q;
  logic [SAMPLER_W*SAMPLE_W-1:0] s2_data_q;

  assign gamma1      = g19_q ? DW'(32'd1 << 19) : DW'(32'd1 << 17);
  assign bus.ready_o = (state_q == StRun) && bus.mem_ready;
  assign accept      = bus.valid_i && bus.ready_o;
  assign last_beat   = (beat_q == BEAT_LAST);
  assign last_poly   = (poly_q == num_poly_q - 3'd1);

  // Security level decode, only latched on an accepted start.
  always_comb begin
    lvl_polys = 3'd7;
    lvl_g19   = 1'b1;
    if (sec_lvl == 3'd2) begin
      lvl_polys = 3'd4;
      lvl_g19   = 1'b0;
    end else if (sec_lvl == 3'd3) begin
      lvl_polys = 3'd5;
    end
  end

  // Next-state logic; DRAIN ends once the final write is taken by the RAM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (accept && last_beat && last_poly) state_d = StDrain;
      StDrain: if (bus.mem_we && bus.mem_ready && s2_sd_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, latched configuration and beat/poly counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      num_poly_q <= 3'd4;
      g19_q      <= 1'b0;
      beat_q     <= '0;
      poly_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && start) begin
        num_poly_q <= lvl_polys;
        g19_q      <= lvl_g19;
        beat_q     <= '0;
        poly_q     <= '0;
      end else if (accept) begin
        if (last_beat) begin
          beat_q <= '0;
          poly_q <= poly_q + 3'd1;
        end else begin
          beat_q <= beat_q + 8'd1;
        end
      end
    end
  end

  // Stage-1 arithmetic: d = gamma1 - r as a signed DW-bit value.
  always_comb begin
    for (int i = 0; i < SAMPLER_W; i++) begin
      d_comb[i] = gamma1 - {1'b0, bus.samples_i[i*SAMPLE_W +: SAMPLE_W]};
    end
  end

  // Stage 1: register the accepted beat, its address and boundary flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_pd_q    <= 1'b0;
      s1_sd_q    <= 1'b0;
      s1_addr_q  <= '0;
      for (int i = 0; i < SAMPLER_W; i++) s1_d_q[i] <= '0;
    end else if (bus.mem_ready) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_addr_q <= ADDR_W'(poly_q) * ADDR_W'(BEATS) + ADDR_W'(beat_q);
        s1_pd_q   <= last_beat;
        s1_sd_q   <= last_beat && last_poly;
        for (int i = 0; i < SAMPLER_W; i++) s1_d_q[i] <= d_comb[i];
      end
    end
  end

  // Stage-2 arithmetic: fold negative d back into [0, q).
  always_comb begin
    for (int i = 0; i < SAMPLER_W; i++) begin
      corr_full[i] = s1_d_q[i][DW-1] ? (s1_d_q[i] + Q) : s1_d_q[i];
      corr[i*SAMPLE_W +: SAMPLE_W] = corr_full[i][SAMPLE_W-1:0];
    end
  end

  // Stage 2: write register; held while the RAM stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_pd_q    <= 1'b0;
      s2_sd_q    <= 1'b0;
      s2_addr_q  <= '0;
      s2_data_q  <= '0;
    end else if (bus.mem_ready) begin
      s2_valid_q <= s1_valid_q;
      s2_pd_q    <= s1_valid_q && s1_pd_q;
      s2_sd_q    <= s1_valid_q && s1_sd_q;
      if (s1_valid_q) begin
        s2_addr_q <= s1_addr_q;
        s2_data_q <= corr;
      end
    end
  end

  assign bus.mem_we    = s2_valid_q;
  assign bus.mem_addr  = s2_addr_q;
  assign bus.mem_wdata = s2_data_q;
  assign poly_done     = s2_pd_q;
  assign set_done      = s2_sd_q;
  assign busy          = (state_q != StIdle);

`ifdef MASK_WR_RANGE_CHK_EN
  logic lane_oor;
  logic range_q;

  // Any lane of the incoming beat outside [0, 2*gamma1).
  always_comb begin
    lane_oor = 1'b0;
    for (int i = 0; i < SAMPLER_W; i++) begin
      if ({1'b0, bus.samples_i[i*SAMPLE_W +: SAMPLE_W]} >= (gamma1 << 1)) lane_oor = 1'b1;
    end
  end

  // Sticky flag, cleared only by an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      range_q <= 1'b0;
    end else if (state_q == StIdle && start) begin
      range_q <= 1'b0;
    end else if (accept && lane_oor) begin
      range_q <= 1'b1;
    end
  end

  assign range_err = range_q;
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_mask_poly_writer.sv
// Scoreboard bench for mask_poly_writer: expected words are pushed on each accepted beat
// and compared against every cycle the write port is active (including stalled cycles).
module tb_mask_poly_writer;
  localparam int SW = 4;
  localparam int SB = 23;
  localparam int AW = 9;
  localparam int BW = SW * SB;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [BW-1:0] data;
    logic          pd;
    logic          sd;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] sec_lvl;
  logic       poly_done, set_done, busy, range_err;

  mask_poly_writer_if #(.SAMPLER_W(SW), .SAMPLE_W(SB), .ADDR_W(AW)) bus ();

  mask_poly_writer #(.SAMPLER_W(SW), .SAMPLE_W(SB), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sec_lvl   (sec_lvl),
    .bus       (bus),
    .poly_done (poly_done),
    .set_done  (set_done),
    .busy      (busy),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_bad = 0;
  exp_t          sb[$];
  logic [BW-1:0] beats [0:447];
  int            beat_idx, total, gamma, wr_cnt, last_addr;
  bit            mon_en, last_seen, chk_first;
  logic [BW-1:0] first_exp;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [SB-1:0] ref_coef(input int r, input int g);
    int d;
    d = g - r;
    if (d < 0) d = d + 8380417;
    return SB'(d);
  endfunction

  function automatic logic [BW-1:0] ref_word(input logic [BW-1:0] s, input int g);
    logic [BW-1:0] w;
    for (int i = 0; i < SW; i++) w[i*SB +: SB] = ref_coef(int'(s[i*SB +: SB]), g);
    return w;
  endfunction

  // One monitor step, taken at the falling edge.
  task automatic mon_step();
    exp_t e;
    if (last_seen) begin
      check("busy_after_last", busy, 0);
      last_seen = 0;
    end
    if (bus.mem_we) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        e = sb[0];
        check("addr", bus.mem_addr, e.addr);
        check("data", bus.mem_wdata, e.data);
        check("poly_done", poly_done, e.pd);
        check("set_done", set_done, e.sd);
        if (chk_first && bus.mem_addr == 0) begin
          check("first_word", bus.mem_wdata, first_exp);
          chk_first = 0;
        end
        if (bus.mem_ready) begin
          void'(sb.pop_front());
          wr_cnt++;
          if (set_done) begin
            last_seen = 1;
            last_addr = int'(bus.mem_addr);
          end
        end
      end
    end else begin
      check("flags_idle", {poly_done, set_done}, 0);
    end
    if (bus.valid_i && bus.ready_o) begin
      e.addr = AW'(beat_idx);
      e.data = ref_word(bus.samples_i, gamma);
      e.pd   = (beat_idx % 64) == 63;
      e.sd   = beat_idx == total - 1;
      sb.push_back(e);
      beat_idx++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_mem_we"}, bus.mem_we, 0);
    check({tag, "_mem_addr"}, bus.mem_addr, 0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    check({tag, "_ready_o"}, bus.ready_o, 0);
    check({tag, "_flags"}, {poly_done, set_done, busy, range_err}, 0);
  endtask

  task automatic run_vec(input logic [2:0] lvl, input int exp_writes, input bit full,
                         input bit stall, input bit disturb, input int abort_at,
                         input bit use_first, input logic [BW-1:0] first_beat,
                         input logic [BW-1:0] fexp);
    int nl, cyc;
    bit rerr;
    logic [SB-1:0] r;
    nl    = (lvl == 3'd2) ? 4 : (lvl == 3'd3) ? 5 : 7;
    gamma = (lvl == 3'd2) ? (1 << 17) : (1 << 19);
    total = nl * 64;
    for (int i = 0; i < total; i++) begin
      for (int j = 0; j < SW; j++) begin
        r = full ? SB'($urandom) : SB'($urandom_range(0, 2 * gamma - 1));
        beats[i][j*SB +: SB] = r;
      end
    end
    if (use_first) beats[0] = first_beat;
    rerr = 0;
`ifdef MASK_WR_RANGE_CHK_EN
    for (int i = 0; i < total; i++)
      for (int j = 0; j < SW; j++)
        if (int'(beats[i][j*SB +: SB]) >= 2 * gamma) rerr = 1;
`endif
    sb.delete();
    beat_idx  = 0;
    wr_cnt    = 0;
    last_addr = -1;
    first_exp = fexp;
    chk_first = use_first;
    mon_en    = 1;

    @(posedge clk); #1;
    sec_lvl = lvl;
    start   = 1;
    bus.valid_i   = 1;
    bus.samples_i = beats[0];
    bus.mem_ready = 1;
    @(posedge clk); #1;
    start = 0;
    check("busy_after_start", busy, 1);
    check("rerr_clear_on_start", range_err, 0);

    cyc = 0;
    while (busy && cyc < 5000) begin
      if (abort_at >= 0 && beat_idx >= abort_at) break;
      bus.valid_i = beat_idx < total;
      if (beat_idx < total) bus.samples_i = beats[beat_idx];
      bus.mem_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (disturb && cyc == 40) begin
        start   = 1;
        sec_lvl = 3'd7;
      end else begin
        start = 0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 0;

    if (abort_at >= 0) begin
      rst = 1;
      mon_en = 0;
      bus.valid_i = 0;
      bus.mem_ready = 1;
      @(posedge clk); #1;
      check_reset_vals("mid_reset");
      rst = 0;
      @(posedge clk); #1;
      check("we_after_reset", bus.mem_we, 0);
      sb.delete();
      last_seen = 0;
      return;
    end

    if (cyc >= 5000) check("timeout", 1, 0);
    bus.valid_i = 0;
    @(negedge clk); #1;
    check("write_count", wr_cnt, exp_writes);
    check("last_addr", last_addr, exp_writes - 1);
    check("sb_empty", sb.size(), 0);
    check("range_err", range_err, rerr);
    repeat (3) @(posedge clk);
    #1;
    check("range_err_sticky", range_err, rerr);
    check("idle_no_write", bus.mem_we, 0);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (mon_en) mon_step();
      end
    join_none

    rst = 1;
    start = 0;
    sec_lvl = 3'd2;
    mon_en = 0;
    last_seen = 0;
    chk_first = 0;
    bus.valid_i = 0;
    bus.samples_i = '0;
    bus.mem_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 0;

    // lvl 2, known first beat
    run_vec(3'd2, 256, 0, 0, 0, -1, 1,
            {23'd262143, 23'd131073, 23'd131072, 23'd0},
            {23'd8249346, 23'd8380416, 23'd0, 23'd131072});
    // lvl 3, known first beat
    run_vec(3'd3, 320, 0, 0, 0, -1, 1,
            {23'd524288, 23'd1, 23'd524289, 23'd0},
            {23'd0, 23'd524287, 23'd8380416, 23'd524288});
    // lvl 2 with an out-of-range sample in lane 1
    run_vec(3'd2, 256, 0, 0, 0, -1, 1,
            {23'd0, 23'd0, 23'd262144, 23'd0},
            {23'd131072, 23'd131072, 23'd8249345, 23'd131072});
    // start and sec_lvl disturbed mid-run
    run_vec(3'd2, 256, 0, 0, 1, -1, 0, '0, '0);
    // lvl 5 (L=7), full-range samples, random RAM stalls
    run_vec(3'd5, 448, 1, 1, 0, -1, 0, '0, '0);
    // reset at beat 100, then a fresh run from addr 0
    run_vec(3'd2, 256, 0, 0, 0, 100, 0, '0, '0);
    run_vec(3'd2, 256, 0, 1, 0, -1, 0, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mask_poly_writer.md
# mask_poly_writer

Consumes the raw uniform samples produced by the ExpandMask sampler and converts each sample r to the centred mask coefficient y = gamma1 − r, reduced into [0, q). It writes the coefficients, SAMPLER_W per word, into the y polynomial RAM consumed by the NTT. It tracks polynomial and vector boundaries over the L polynomials of one mask vector, and sits directly downstream of the sampler's valid/ready sample stream.

## Interface
- SAMPLER_W, 4, coefficients per beat/RAM word; power of 2 dividing 256
- SAMPLE_W, 23, bits per coefficient
- ADDR_W, 9, RAM word-address width; must satisfy 7*256/SAMPLER_W ≤ 2^ADDR_W
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- start  in  1  begin one mask vector (L polynomials); ignored unless IDLE
- sec_lvl  in  3  2 → L=4, gamma1=2^17; 3 → L=5, gamma1=2^19; other → L=7, gamma1=2^19; sampled on accepted start
- samples_i  in  SAMPLER_W*SAMPLE_W  raw samples, lane 0 in LSBs
- valid_i  in  1  samples_i valid
- ready_o  out  1  beat accepted when valid_i && ready_o
- mem_ready  in  1  RAM accepts write; low stalls whole pipeline
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_W  word address = poly*(256/SAMPLER_W) + beat
- mem_wdata  out  SAMPLER_W*SAMPLE_W  reduced coefficients, lane order preserved
- poly_done  out  1  pulse with last write of each polynomial
- set_done  out  1  pulse with last write of the vector
- busy  out  1  state ≠ IDLE
- range_err  out  1  sticky sample-range error (see Configuration)

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: on start, latch L and gamma1, clear beat counter, poly counter and range_err, go to RUN.
- RUN: ready_o = mem_ready && (accepted beats < L*256/SAMPLER_W). Acceptance of the final beat moves to DRAIN.
- DRAIN: ready_o=0. Leave for IDLE the cycle after the final mem_we.
- start while busy is ignored, and sec_lvl changes while busy have no effect.
- Per lane:
  - r = lane[SAMPLE_W-1:0].
  - d = gamma1 − r, computed as a 24-bit signed value.
  - Output d if d ≥ 0, otherwise d + 8380417. The result is always in [0, 8380416].
- Beat counter wraps at 256/SAMPLER_W−1, incrementing the poly counter. poly_done asserts on the write whose beat index = 256/SAMPLER_W−1. set_done asserts together with poly_done when poly = L−1.

## Timing
- 2-stage pipeline:
  - stage 1 registers the accepted beat and computes d;
  - stage 2 performs the mod-q correction and drives mem_we, mem_addr and mem_wdata.
- Write occurs 2 cycles after acceptance when mem_ready is held high.
- mem_ready=0 freezes both stages and holds mem_we, mem_addr and mem_wdata stable. The write completes in the first cycle where mem_we && mem_ready.
- valid_i with ready_o=0 does not consume the beat. The upstream sampler must hold the beat.
- Back-to-back beats are sustained at one per cycle. A full vector takes L*256/SAMPLER_W + 2 cycles minimum from the first acceptance (lvl 2, SAMPLER_W=4: 258).
- Reset values: state IDLE, ready_o=0, mem_we=0, mem_addr=0, mem_wdata=0, poly_done=0, set_done=0, busy=0, range_err=0.
- Reset mid-operation flushes the pipeline immediately; no further writes occur.

## Configuration
- MASK_WR_RANGE_CHK_EN defined: each accepted lane with r ≥ 2*gamma1 sets range_err. range_err stays set until the next accepted start or rst. The data is still written, unmodified by the check.
- MASK_WR_RANGE_CHK_EN undefined: no comparator logic, and range_err is tied to 0.

## Test plan
- lvl 2, SAMPLER_W=4, valid_i always high, mem_ready high, first beat lanes {0, 131072, 131073, 262143} → first write addr 0, lanes {131072, 0, 8380416, 8249346}. The run gives 256 writes, poly_done at addr 63/127/191/255, set_done at addr 255 only, busy low the cycle after.
- lvl 3, sample r=0 → 524288; r=524289 → 8380416. The run gives 320 writes, and the last write goes to addr 319.
- mem_ready toggled randomly during a lvl 5 run → 448 writes, strictly increasing addresses with none skipped or repeated. Outputs are held stable while stalled, and the data matches the reference model.
- start pulsed while busy, and sec_lvl changed mid-run → no effect; the write count matches the latched level.
- rst asserted on beat 100 of a lvl 2 run → mem_we low from the next cycle, and all outputs at reset values. A new start then begins again at addr 0.
- With MASK_WR_RANGE_CHK_EN, lvl 2 sample 262144 → range_err=1 and stays high until the next start. Without the macro, range_err stays 0.
